fp_addsub_pipe: RTL and testbench

FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

---
 rtl/fp_addsub_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined IEEE-754-format adder/subtractor with valid/ready handshakes,
// flush-to-zero for subnormals and round-to-nearest-even.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;             // hidden bit + fraction + guard/round/sticky
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + 2;             // signed exponent with headroom both ways
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    function automatic logic [LZW-1:0] count_lz(input logic [SW-1:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic adv;
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    // S1: unpack, special cases, effective operation, magnitude compare/swap
    logic             sa, sb, eff_sub, swap;
    logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W:0]   ma, mb;
    logic             sp1;
    logic [W-1:0]     sp1_res;
    logic [3:0]       sp1_flags;

    assign sa      = a[W-1];
    assign sb      = b[W-1] ^ op;
    assign ea      = a[W-2:MAN_W];
    assign eb      = b[W-2:MAN_W];
    assign ma      = (ea == '0) ? '0 : {1'b1, a[MAN_W-1:0]};
    assign mb      = (eb == '0) ? '0 : {1'b1, b[MAN_W-1:0]};
    assign a_nan   = (&ea) && (|a[MAN_W-1:0]);
    assign b_nan   = (&eb) && (|b[MAN_W-1:0]);
    assign a_snan  = a_nan && !a[MAN_W-1];
    assign b_snan  = b_nan && !b[MAN_W-1];
    assign a_inf   = (&ea) && !(|a[MAN_W-1:0]);
    assign b_inf   = (&eb) && !(|b[MAN_W-1:0]);
    assign eff_sub = sa ^ sb;
    assign swap    = {eb, mb} > {ea, ma};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        sp1       = 1'b0;
        sp1_res   = '0;
        sp1_flags = '0;
        if (a_nan || b_nan) begin
            sp1       = 1'b1;
            sp1_res   = QNAN;
            sp1_flags = {a_snan | b_snan, 3'b000};
        end else if (a_inf && b_inf && eff_sub) begin
            sp1       = 1'b1;
            sp1_res   = QNAN;
            sp1_flags = 4'b1000;
        end else if (a_inf) begin
            sp1     = 1'b1;
            sp1_res = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            sp1     = 1'b1;
            sp1_res = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    logic             s1_valid, s1_special, s1_sign, s1_zero_sign, s1_eff_sub;
    logic [W-1:0]     s1_spec_res;
    logic [3:0]       s1_spec_flags;
    logic [EXP_W-1:0] s1_exp, s1_diff;
    logic [MAN_W:0]   s1_man_big, s1_man_small;

    // S2: alignment with sticky collection, then add or subtract magnitudes
    logic [EXP_W-1:0] sh;
    logic [SW-1:0]    small_ext, big_ext, shifted, aligned;
    logic             lost;
    logic [SW:0]      sum2;

    assign sh        = (s1_diff > EXP_W'(SW - 1)) ? EXP_W'(SW - 1) : s1_diff;
    assign small_ext = {s1_man_small, 3'b000};
    assign big_ext   = {s1_man_big, 3'b000};
    assign shifted   = small_ext >> sh;
    assign lost      = |(small_ext & ~({SW{1'b1}} << sh));
    assign aligned   = {shifted[SW-1:1], shifted[0] | lost};
    assign sum2      = s1_eff_sub ? ({1'b0, big_ext} - {1'b0, aligned})
                                  : ({1'b0, big_ext} + {1'b0, aligned});

    logic             s2_valid, s2_special, s2_sign, s2_zero_sign;
    logic [W-1:0]     s2_spec_res;
    logic [3:0]       s2_spec_flags;
    logic [EXP_W-1:0] s2_exp;
    logic [SW:0]      s2_sum;

    // S3: normalize, round to nearest even, range-check, pack
    logic [SW-1:0]          norm;
    logic [LZW-1:0]         lz;
    logic signed [EW-1:0]   exp_n, exp_r;
    logic [MAN_W+1:0]       mant_r;
    logic [MAN_W-1:0]       frac;
    logic                   inexact, round_up;
    logic [W-1:0]           res3;
    logic [3:0]             flg3;

    always_comb begin
        norm     = '0;
        lz       = '0;
        exp_n    = '0;
        exp_r    = '0;
        mant_r   = '0;
        frac     = '0;
        inexact  = 1'b0;
        round_up = 1'b0;
        res3     = '0;
        flg3     = '0;
        if (s2_special) begin
            res3 = s2_spec_res;
            flg3 = s2_spec_flags;
        end else if (s2_sum == '0) begin
            res3 = {s2_zero_sign, {(W-1){1'b0}}};
        end else begin
            if (s2_sum[SW]) begin
                norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
                exp_n = $signed({2'b00, s2_exp}) + EW'(1);
            end else begin
                lz    = count_lz(s2_sum[SW-1:0]);
                norm  = s2_sum[SW-1:0] << lz;
                exp_n = $signed({2'b00, s2_exp}) - $signed({{(EW-LZW){1'b0}}, lz});
            end
            inexact  = |norm[2:0];
            round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
            mant_r   = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(round_up);
            if (mant_r[MAN_W+1]) begin
                exp_r = exp_n + EW'(1);
                frac  = mant_r[MAN_W:1];
            end else begin
                exp_r = exp_n;
                frac  = mant_r[MAN_W-1:0];
            end
            if (exp_r <= EW'(0)) begin
                res3 = {s2_sign, {(W-1){1'b0}}};
                flg3 = 4'b0011;
            end else if (exp_r >= EXP_MAX) begin
                res3 = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flg3 = 4'b0101;
            end else begin
                res3 = {s2_sign, exp_r[EXP_W-1:0], frac};
                flg3 = {3'b000, inexact};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                result <= res3;
                flags  <= flg3;
            end
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_special    <= sp1;
            s1_spec_res   <= sp1_res;
            s1_spec_flags <= sp1_flags;
            s1_eff_sub    <= eff_sub;
            s1_sign       <= swap ? sb : sa;
            s1_zero_sign  <= sa & ~eff_sub;
            s1_exp        <= swap ? eb : ea;
            s1_diff       <= swap ? (eb - ea) : (ea - eb);
            s1_man_big    <= swap ? mb : ma;
            s1_man_small  <= swap ? ma : mb;

            s2_special    <= s1_special;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sign;
            s2_zero_sign  <= s1_zero_sign;
            s2_exp        <= s1_exp;
            s2_sum        <= sum2;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: exact-integer reference model with scoreboard,
// directed vectors, back-pressure, throughput and mid-flight reset scenarios.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: operands become exact integers in units of 2^-149, summed exactly,
    // then rounded to 24 significant bits with ties to even. Returns {flags, result}.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic        sx, sy, xn, yn, xs, ys, sr;
        logic [7:0]  ex, ey;
        logic [22:0] fx, fy;
        logic [299:0] mx, my, mag, mask, rem, half, mant_w;
        logic [24:0] mant;
        logic        nx, up;
        int          p, sh, e;
        sx = x[31]; ex = x[30:23]; fx = x[22:0];
        sy = y[31] ^ sub; ey = y[30:23]; fy = y[22:0];
        xn = (ex == 8'hFF) && (fx != 0);
        yn = (ey == 8'hFF) && (fy != 0);
        xs = xn && !fx[22];
        ys = yn && !fy[22];
        if (xn || yn) return {xs | ys, 3'b000, 32'h7FC00000};
        if (ex == 8'hFF && ey == 8'hFF)
            return (sx == sy) ? {4'b0000, sx, 8'hFF, 23'd0} : {4'b1000, 32'h7FC00000};
        if (ex == 8'hFF) return {4'b0000, sx, 8'hFF, 23'd0};
        if (ey == 8'hFF) return {4'b0000, sy, 8'hFF, 23'd0};
        mx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (int'(ex) - 1));
        my = (ey == 0) ? '0 : (300'({1'b1, fy}) << (int'(ey) - 1));
        if (sx == sy)      begin mag = mx + my; sr = sx; end
        else if (mx >= my) begin mag = mx - my; sr = sx; end
        else               begin mag = my - mx; sr = sy; end
        if (mag == 0) return {4'b0000, (sx == sy) ? sx : 1'b0, 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {4'b0011, sr, 31'd0};
        sh     = p - 23;
        mant_w = mag >> sh;
        mant   = mant_w[24:0];
        mask   = (300'(1) << sh) - 300'(1);
        rem    = mag & mask;
        half   = (sh > 0) ? (300'(1) << (sh - 1)) : '0;
        nx     = (rem != 0);
        up     = (sh > 0) && ((rem > half) || (rem == half && mant[0]));
        mant   = mant + 25'(up);
        if (mant[24]) begin mant = mant >> 1; sh++; end
        e = sh + 1;
        if (e >= 255) return {4'b0101, sr, 8'hFF, 23'd0};
        return {3'b000, nx, sr, 8'(e), mant[22:0]};
    endfunction

    // Scoreboard and hold checker, sampled on the falling edge
    logic [35:0] exp_q[$];
    int          cyc = 0;
    int          out_cyc[$];
    logic        stall_prev = 1'b0;
    logic [35:0] held = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({flags, result}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
                else begin
                    check("scoreboard", 64'({flags, result}), 64'(exp_q.pop_front()));
                    out_cyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, op));
            stall_prev = out_valid && !out_ready;
            held       = {flags, result};
        end
    end

    localparam int NV = 17;
    logic [31:0] tv_a[NV];
    logic [31:0] tv_b[NV];
    logic        tv_op[NV];
    logic [35:0] tv_r[NV];

    task automatic present(input logic [31:0] va, input logic [31:0] vb, input logic vop);
        a = va; b = vb; op = vop; in_valid = 1'b1; out_ready = 1'b1;
    endtask

    // Completes a single transfer already presented, measures latency, checks literal result
    task automatic finish_one(input logic [35:0] req, input string name);
        int lat;
        bit seen;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                lat++;
            end
        end
        if (!seen) check({name, "_timeout"}, 64'(out_valid), 64'd1);
        else begin
            check({name, "_latency"}, 64'(lat), 64'd3);
            check(name, 64'({flags, result}), 64'(req));
        end
    endtask

    task automatic run_one(input int idx);
        @(posedge clk); #1;
        present(tv_a[idx], tv_b[idx], tv_op[idx]);
        finish_one(tv_r[idx], $sformatf("vec%0d", idx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int i, c, base;
        int pat[4];
        pat = '{1, 0, 0, 1};
        tv_a  = '{32'h40400000, 32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000,
                  32'h00800001, 32'h7F800001, 32'h3F800000, 32'h3F800000, 32'h3F800001, 32'hC0000000,
                  32'hFF800000, 32'h3F800000, 32'h00000001, 32'h7FC00000, 32'h3F800000};
        tv_b  = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F800000, 32'h7F7FFFFF, 32'h33800000,
                  32'h00800000, 32'h3F800000, 32'h34000000, 32'h33C00000, 32'h33800000, 32'h3F800000,
                  32'h3F800000, 32'hFF800000, 32'h3F800000, 32'h00000000, 32'h4B800000};
        tv_op = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tv_r  = '{{4'h0, 32'h40000000}, {4'h0, 32'h00000000}, {4'h0, 32'h80000000}, {4'h8, 32'h7FC00000},
                  {4'h5, 32'h7F800000}, {4'h1, 32'h3F800000}, {4'h3, 32'h00000000}, {4'h8, 32'h7FC00000},
                  {4'h0, 32'h3F800001}, {4'h1, 32'h3F800001}, {4'h1, 32'h3F800002}, {4'h0, 32'hBF800000},
                  {4'h0, 32'hFF800000}, {4'h0, 32'h7F800000}, {4'h0, 32'h3F800000}, {4'h0, 32'h7FC00000},
                  {4'h1, 32'h4B800000}};

        // Pin the reference model on hand-computed cases
        check("model_sub", 64'(model(32'h40400000, 32'h3F800000, 1'b1)), 64'({4'h0, 32'h40000000}));
        check("model_tie", 64'(model(32'h3F800000, 32'h33800000, 1'b0)), 64'({4'h1, 32'h3F800000}));
        check("model_ovf", 64'(model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0)), 64'({4'h5, 32'h7F800000}));
        check("model_negz", 64'(model(32'h80000000, 32'h80000000, 1'b0)), 64'({4'h0, 32'h80000000}));

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Release and present on the same cycle: first rising edge must accept
        @(posedge clk); #1;
        rst_n = 1'b1;
        present(tv_a[0], tv_b[0], tv_op[0]);
        finish_one(tv_r[0], "first_after_reset");

        for (int k = 1; k < NV; k++) run_one(k);

        // Full throughput: eight back-to-back operations with out_ready held high
        repeat (3) @(posedge clk);
        base = out_cyc.size();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            present(tv_a[k + 4], tv_b[k + 4], tv_op[k + 4]);
            @(negedge clk);
            check("tput_in_ready", 64'(in_ready), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        check("tput_count", 64'(out_cyc.size() - base), 64'd8);
        if (out_cyc.size() - base == 8)
            check("tput_no_bubble", 64'(out_cyc[base + 7] - out_cyc[base]), 64'd7);

        // Back-pressure: out_ready follows 1,0,0,1 while eight operations stream in
        base = out_cyc.size();
        i = 0;
        c = 0;
        while (i < 8 && c < 200) begin
            @(posedge clk); #1;
            out_ready = pat[c % 4] != 0;
            c++;
            a = tv_a[i + 8]; b = tv_b[i + 8]; op = tv_op[i + 8]; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) i++;
        end
        check("bp_all_accepted", 64'(i), 64'd8);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 24; k++) begin
            out_ready = pat[c % 4] != 0;
            c++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        check("bp_count", 64'(out_cyc.size() - base), 64'd8);
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-flight: two accepted operations are discarded
        @(posedge clk); #1;
        present(tv_a[4], tv_b[4], tv_op[4]);
        @(posedge clk); #1;
        present(tv_a[5], tv_b[5], tv_op[5]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("midrst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        present(tv_a[9], tv_b[9], tv_op[9]);
        finish_one(tv_r[9], "after_midrst");
        repeat (3) @(posedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
